toy_bus_age_issue_buf: RTL and testbench
========================================

TOY_BUS_AGE_ISSUE_BUF -- requirements
Module: toy_bus_age_issue_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, fixed at 4, meaning the number of buffer entries and the age-matrix order.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_vld  input  1  producer offers an entry.
REQ-006 in_rdy  output  1  buffer can accept an entry.
REQ-007 in_dest  input  2  destination ID of the offered entry.
REQ-008 in_data  input  DATA_W  payload of the offered entry.
REQ-009 dest_rdy  input  4  per-destination ready mask; bit d set means destination d can accept.
REQ-010 out_vld  output  1  an eligible entry is presented.
REQ-011 out_rdy  input  1  consumer accepts the presented entry.
REQ-012 out_dest  output  2  destination of the presented entry.
REQ-013 out_data  output  DATA_W  payload of the presented entry.
REQ-014 out_idx  output  2  buffer slot index of the presented entry.
REQ-015 occupancy  output  3  number of valid entries, 0 to 4.

Function
REQ-016 Each entry SHALL hold vld, dest and data; the buffer SHALL also hold a 4x4 age matrix in which age[i][j]=1 means entry i is older than entry j, and the diagonal reads 0.
REQ-017 in_rdy SHALL be 1 when at least one entry is invalid, and SHALL be driven from registered state only (no path from out_rdy or dest_rdy).
REQ-018 An in_vld&&in_rdy transfer SHALL write the lowest-index invalid entry k at the clock edge: vld[k]=1, age[k][*]=0, age[j][k]=1 for all j!=k.
REQ-019 An entry SHALL be eligible when vld[i]=1 and dest_rdy[vld dest of i]=1.
REQ-020 The selected entry SHALL be the eligible i for which no eligible j has age[j][i]=1, i.e. the oldest eligible entry.
REQ-021 out_vld SHALL equal the OR of eligibility; out_dest, out_data and out_idx SHALL be combinational from the selected entry, and SHALL read 0 when out_vld=0.
REQ-022 out_vld/out_idx MAY change without a handshake when dest_rdy changes; the consumer SHALL NOT assume AXI-style stability.
REQ-023 An out_vld&&out_rdy transfer SHALL clear vld[out_idx] at the clock edge; the age bits of that entry are don't-care while it is invalid.
REQ-024 Minimum latency SHALL be 1 cycle: an entry written at edge N is presentable in cycle N+1.
REQ-025 Enqueue and dequeue in the same cycle SHALL both occur; a slot freed in cycle N SHALL NOT be reallocated in cycle N (the allocation target is computed from pre-edge vld); occupancy SHALL be unchanged.
REQ-026 When full, in_rdy=0 and occupancy=4; when empty, out_vld=0 and occupancy=0.
REQ-027 Two entries with the same dest SHALL leave in arrival order; entries with different dests MAY leave out of order.
REQ-028 Age order SHALL remain a strict total order over valid entries after any sequence of allocation and free operations.

Reset
REQ-029 While rst_n=0: all vld=0, the age matrix is all 0, and data/dest are don't-care.
REQ-030 Reset outputs SHALL be in_rdy=1, out_vld=0, out_dest=0, out_data=0, out_idx=0, occupancy=0.
REQ-031 Assertion of rst_n mid-operation SHALL discard all entries immediately without completing handshakes; the first accept is possible at the first edge after deassertion.

Structure
REQ-032 A shared package SHALL hold the constants DEPTH=4, IDX_W=2, DEST_W=2 and an entry struct typedef {vld, dest, data}.
REQ-033 The age matrix SHALL be a sub-module toy_bus_age_mtx_alloc with inputs clk, rst_n, alloc_en[3:0] (one-hot) and outputs age_row_0..3[3:0], implementing REQ-018 and REQ-029.
REQ-034 Oldest-eligible selection and lowest-free allocation SHALL stay in toy_bus_age_issue_buf.

Verification
REQ-035 Fill: with dest_rdy=0, enqueue A(d0), B(d1), C(d0), D(d2) -> slots 0..3, in_rdy=0, occupancy=4, out_vld=0.
REQ-036 Oldest-eligible: from REQ-035, set dest_rdy=4'b0010 -> out_idx=1 (B); then set dest_rdy=4'b0001 -> A, then C, in that order.
REQ-037 Reuse/age: from full, dequeue slot 0, then enqueue E(d2) -> E lands in slot 0; with dest_rdy=4'b0100 the order is D then E.
REQ-038 Simultaneous: with 3 entries, enqueue and dequeue in the same cycle -> occupancy stays 3, the freed slot is not written that cycle, and the new entry is presented only after all older eligible entries.
REQ-039 Reset mid-stream: assert rst_n low with 2 valid entries and out_vld=1 -> next observation: out_vld=0, occupancy=0, in_rdy=1; after release, a fresh entry is out 1 cycle after acceptance.
REQ-040 Random: with random in_vld/out_rdy/dest_rdy over 10k cycles, a scoreboard checks per-dest FIFO order, no loss or duplication, and occupancy equal to the model.

Source files
------------

// File: rtl/toy_bus_age_issue_buf_pkg.sv
// Shared constants and types for the age-ordered issue buffer.
//   DEPTH / IDX_W / DEST_W / OCC_W : buffer geometry
//   entry_t                        : one buffer slot {vld, dest, data}
//   popcnt()                       : occupancy count of a valid mask
package toy_bus_age_issue_buf_pkg;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned DEST_W     = 2;
  localparam int unsigned OCC_W      = 3;
  localparam int unsigned PKG_DATA_W = 32;

  typedef struct packed {
    logic                  vld;
    logic [DEST_W-1:0]     dest;
    logic [PKG_DATA_W-1:0] data;
  } entry_t;

  function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      n = n + OCC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/toy_bus_age_issue_buf_if.sv
// Handshake bundle of the issue buffer.
//   producer side : in_vld, in_rdy, in_dest, in_data
//   consumer side : dest_rdy, out_vld, out_rdy, out_dest, out_data, out_idx
//   status        : occupancy
// slave = the buffer, master = the environment driving it.
interface toy_bus_age_issue_buf_if
  import toy_bus_age_issue_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);
  logic              in_vld;
  logic              in_rdy;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        dest_rdy;
  logic              out_vld;
  logic              out_rdy;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  in_vld, in_dest, in_data, dest_rdy, out_rdy,
    output in_rdy, out_vld, out_dest, out_data, out_idx, occupancy
  );

  modport master (
    output in_vld, in_dest, in_data, dest_rdy, out_rdy,
    input  in_rdy, out_vld, out_dest, out_data, out_idx, occupancy
  );
endinterface

// File: rtl/toy_bus_age_mtx_alloc.sv
// Age matrix for the issue buffer. age_row_i[j]=1 means entry i is older than j.
//   clk, rst_n : clock, asynchronous active-low reset (matrix clears to 0)
//   alloc_en   : one-hot slot being written this edge
//   age_row_0..3 : matrix rows
// A freshly allocated entry becomes younger than every other entry. Rows of
// freed entries are left stale; consumers mask them with the valid bits.
module toy_bus_age_mtx_alloc
  import toy_bus_age_issue_buf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_en,
  output logic [DEPTH-1:0] age_row_0,
  output logic [DEPTH-1:0] age_row_1,
  output logic [DEPTH-1:0] age_row_2,
  output logic [DEPTH-1:0] age_row_3
);

  logic [DEPTH-1:0] r_age [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (alloc_en[i]) begin
          r_age[i] <= '0;
        end else if (|alloc_en) begin
          // alloc_en[i]=0 here, so the diagonal is never set
          r_age[i] <= r_age[i] | alloc_en;
        end
      end
    end
  end

  assign age_row_0 = r_age[0];
  assign age_row_1 = r_age[1];
  assign age_row_2 = r_age[2];
  assign age_row_3 = r_age[3];

endmodule

// File: rtl/toy_bus_age_issue_buf.sv
// Four-entry issue buffer that presents the oldest entry whose destination is
// ready. Allocation takes the lowest free slot; age ordering is kept in
// toy_bus_age_mtx_alloc.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of toy_bus_age_issue_buf_if (producer handshake,
//                per-destination ready, consumer handshake, occupancy)
module toy_bus_age_issue_buf
  import toy_bus_age_issue_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  toy_bus_age_issue_buf_if.slave   bus
);

  // Slot payload width is the package entry width; the top parameters are
  // only allowed to restate it.
  if (DATA_W != PKG_DATA_W || DEPTH != toy_bus_age_issue_buf_pkg::DEPTH) begin : g_param_chk
    $error("toy_bus_age_issue_buf: DATA_W/DEPTH must match the package");
  end

  entry_t           r_ent [DEPTH];
  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_alloc_oh;
  logic [DEPTH-1:0] w_alloc_en;
  logic [DEPTH-1:0] w_age_row [DEPTH];
  logic             w_enq;
  logic             w_deq;

  toy_bus_age_mtx_alloc u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_en  (w_alloc_en),
    .age_row_0 (w_age_row[0]),
    .age_row_1 (w_age_row[1]),
    .age_row_2 (w_age_row[2]),
    .age_row_3 (w_age_row[3])
  );

  always_comb begin
    w_vld  = '0;
    w_elig = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_vld[i]  = r_ent[i].vld;
      w_elig[i] = r_ent[i].vld & bus.dest_rdy[r_ent[i].dest];
    end
  end

  // Oldest eligible: no other eligible entry claims to be older than it.
  always_comb begin
    logic w_blocked;
    w_sel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_blocked = 1'b0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (w_elig[j] && w_age_row[j][i]) w_blocked = 1'b1;
      end
      w_sel[i] = w_elig[i] & ~w_blocked;
    end
  end

  // Lowest-index free slot, from pre-edge valid bits only.
  always_comb begin
    w_alloc_oh = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!w_vld[i]) w_alloc_oh = DEPTH'(1) << i;
    end
  end

  assign w_enq      = bus.in_vld & bus.in_rdy;
  assign w_deq      = bus.out_vld & bus.out_rdy;
  assign w_alloc_en = w_enq ? w_alloc_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_alloc_en[i]) begin
          r_ent[i] <= '{vld: 1'b1, dest: bus.in_dest, data: bus.in_data};
        end else if (w_deq && w_sel[i]) begin
          r_ent[i].vld <= 1'b0;
        end
      end
    end
  end

  // w_sel is one-hot or zero, so OR-muxing yields zeros when nothing is eligible.
  always_comb begin
    bus.out_dest = '0;
    bus.out_data = '0;
    bus.out_idx  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_sel[i]) begin
        bus.out_dest = bus.out_dest | r_ent[i].dest;
        bus.out_data = bus.out_data | r_ent[i].data;
        bus.out_idx  = bus.out_idx | IDX_W'(i);
      end
    end
  end

  assign bus.out_vld   = |w_elig;
  assign bus.in_rdy    = ~&w_vld;
  assign bus.occupancy = popcnt(w_vld);

endmodule

// File: tb/tb_toy_bus_age_issue_buf.sv
module tb_toy_bus_age_issue_buf;
  import toy_bus_age_issue_buf_pkg::*;

  logic clk;
  logic rst_n;

  toy_bus_age_issue_buf_if #(.DATA_W(32)) bus ();

  toy_bus_age_issue_buf #(.DATA_W(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_enq = 0;
  int n_deq = 0;

  // Model: slot table plus an arrival-ordered list of occupied slots.
  bit          m_vld  [4];
  logic [1:0]  m_dest [4];
  logic [31:0] m_data [4];
  int          m_order[$];
  typedef logic [31:0] dq_t[$];
  dq_t         dq[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int m_sel(input logic [3:0] drdy);
    foreach (m_order[k]) begin
      if (drdy[m_dest[m_order[k]]]) return m_order[k];
    end
    return -1;
  endfunction

  function automatic int m_alloc();
    for (int i = 0; i < 4; i++) if (!m_vld[i]) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    m_order.delete();
    for (int d = 0; d < 4; d++) dq[d].delete();
  endtask

  task automatic cmp_model();
    int s;
    int cnt;
    s   = m_sel(bus.dest_rdy);
    cnt = m_order.size();
    chk("in_rdy",    64'(bus.in_rdy),    64'(cnt < 4));
    chk("out_vld",   64'(bus.out_vld),   64'(s >= 0));
    chk("out_idx",   64'(bus.out_idx),   (s >= 0) ? 64'(s) : 64'd0);
    chk("out_dest",  64'(bus.out_dest),  (s >= 0) ? 64'(m_dest[s]) : 64'd0);
    chk("out_data",  64'(bus.out_data),  (s >= 0) ? 64'(m_data[s]) : 64'd0);
    chk("occupancy", 64'(bus.occupancy), 64'(cnt));
  endtask

  task automatic step(input logic vld, input logic [1:0] dest, input logic [31:0] data,
                      input logic [3:0] drdy, input logic ordy);
    int s;
    int a;
    bit enq;
    bit deq;
    logic [31:0] exp_d;
    @(negedge clk);
    bus.in_vld   = vld;
    bus.in_dest  = dest;
    bus.in_data  = data;
    bus.dest_rdy = drdy;
    bus.out_rdy  = ordy;
    #1;
    cmp_model();
    s   = m_sel(drdy);
    a   = m_alloc();
    enq = vld && (m_order.size() < 4);
    deq = ordy && (s >= 0);
    if (deq) begin
      exp_d = dq[m_dest[s]].pop_front();
      chk("dest_fifo", 64'(bus.out_data), 64'(exp_d));
    end
    @(posedge clk);
    if (deq) begin
      m_vld[s] = 1'b0;
      foreach (m_order[k]) if (m_order[k] == s) begin m_order.delete(k); break; end
      n_deq++;
    end
    if (enq) begin
      m_vld[a]  = 1'b1;
      m_dest[a] = dest;
      m_data[a] = data;
      m_order.push_back(a);
      dq[dest].push_back(data);
      n_enq++;
    end
  endtask

  // Present a dest_rdy pattern with no handshakes; state does not move.
  task automatic peek(input logic [3:0] drdy);
    @(negedge clk);
    bus.in_vld   = 1'b0;
    bus.out_rdy  = 1'b0;
    bus.dest_rdy = drdy;
    #1;
    cmp_model();
  endtask

  // Returns shortly after a rising edge with rst_n released, so the next
  // step() lands its handshake on the first edge after deassertion.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    #1;
    chk("rst_in_rdy",  64'(bus.in_rdy),    64'd1);
    chk("rst_out_vld", 64'(bus.out_vld),   64'd0);
    chk("rst_dest",    64'(bus.out_dest),  64'd0);
    chk("rst_data",    64'(bus.out_data),  64'd0);
    chk("rst_idx",     64'(bus.out_idx),   64'd0);
    chk("rst_occ",     64'(bus.occupancy), 64'd0);
    m_clear();
    n_enq = 0;
    n_deq = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_vld   = 1'b0;
    bus.in_dest  = '0;
    bus.in_data  = '0;
    bus.dest_rdy = '0;
    bus.out_rdy  = 1'b0;
    do_reset();

    // Fill with all destinations blocked.
    step(1'b1, 2'd0, 32'hA, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 32'hB, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 32'hC, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 32'hD, 4'b0000, 1'b0);
    peek(4'b0000);
    chk("fill_in_rdy", 64'(bus.in_rdy),    64'd0);
    chk("fill_occ",    64'(bus.occupancy), 64'd4);
    chk("fill_vld",    64'(bus.out_vld),   64'd0);

    // Oldest eligible.
    peek(4'b0010);
    chk("oe_b_idx",  64'(bus.out_idx),  64'd1);
    chk("oe_b_data", 64'(bus.out_data), 64'hB);
    step(1'b0, 2'd0, 32'h0, 4'b0010, 1'b1);
    peek(4'b0001);
    chk("oe_a_idx", 64'(bus.out_idx), 64'd0);
    step(1'b0, 2'd0, 32'h0, 4'b0001, 1'b1);
    peek(4'b0001);
    chk("oe_c_idx", 64'(bus.out_idx), 64'd2);
    step(1'b0, 2'd0, 32'h0, 4'b0001, 1'b1);

    // Refill to full with d3 entries in slots 0..2, then reuse slot 0.
    step(1'b1, 2'd3, 32'h31, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 32'h32, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 32'h33, 4'b0000, 1'b0);
    peek(4'b1000);
    chk("reuse_full", 64'(bus.occupancy), 64'd4);
    chk("reuse_idx0", 64'(bus.out_idx),   64'd0);
    step(1'b0, 2'd0, 32'h0, 4'b1000, 1'b1);
    step(1'b1, 2'd2, 32'hE, 4'b0000, 1'b0);
    peek(4'b0100);
    chk("reuse_d_idx", 64'(bus.out_idx), 64'd3);
    step(1'b0, 2'd0, 32'h0, 4'b0100, 1'b1);
    peek(4'b0100);
    chk("reuse_e_idx",  64'(bus.out_idx),  64'd0);
    chk("reuse_e_data", 64'(bus.out_data), 64'hE);
    step(1'b0, 2'd0, 32'h0, 4'b0100, 1'b1);

    // Simultaneous enqueue/dequeue with three entries (slots 1,2,0 in age order).
    step(1'b1, 2'd3, 32'h59, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 32'h5A, 4'b1000, 1'b1);
    peek(4'b1000);
    chk("simul_occ", 64'(bus.occupancy), 64'd3);
    chk("simul_idx", 64'(bus.out_idx),   64'd2);
    step(1'b0, 2'd0, 32'h0, 4'b1000, 1'b1);
    peek(4'b1000);
    chk("simul_y", 64'(bus.out_idx), 64'd0);
    step(1'b0, 2'd0, 32'h0, 4'b1000, 1'b1);
    peek(4'b1000);
    chk("simul_z_idx",  64'(bus.out_idx),  64'd3);
    chk("simul_z_data", 64'(bus.out_data), 64'h5A);
    step(1'b0, 2'd0, 32'h0, 4'b1000, 1'b1);

    // Reset mid-stream.
    step(1'b1, 2'd0, 32'h71, 4'b0001, 1'b0);
    step(1'b1, 2'd0, 32'h72, 4'b0001, 1'b0);
    peek(4'b0001);
    chk("mid_vld", 64'(bus.out_vld), 64'd1);
    do_reset();
    step(1'b1, 2'd1, 32'h77, 4'b0010, 1'b0);
    peek(4'b0010);
    chk("post_rst_vld",  64'(bus.out_vld),  64'd1);
    chk("post_rst_idx",  64'(bus.out_idx),  64'd0);
    chk("post_rst_data", 64'(bus.out_data), 64'h77);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    peek(4'b0000);
    chk("conservation", 64'(bus.occupancy), 64'(n_enq - n_deq));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
